// File: rtl/pcap_replay_pkg.sv
// Shared constants and types for the pcap replay unpacker stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FIFO word field positions, bus widths, FIFO word struct, strobe-mask helper.
package pcap_replay_pkg;

    localparam int FIFO_W  = 144;
    localparam int AXIS_W  = 64;
    localparam int STRB_W  = AXIS_W / 8;
    localparam int DATA_W  = 128;
    localparam int SOP_BIT = 128;
    localparam int EOP_BIT = 129;
    localparam int NB_LO   = 130;
    localparam int NB_HI   = 133;

    // Packed view of one upstream FIFO word, MSB first.
    typedef struct packed {
        logic [9:0]        rsvd;
        logic [3:0]        nbytes_m1;
        logic              eop;
        logic              sop;
        logic [DATA_W-1:0] data;
    } fifo_word_t;

    // Low-order byte mask for nb valid bytes, nb in 1..8.
    function automatic logic [STRB_W-1:0] strb_mask(input logic [3:0] nb);
        logic [3:0] shift;
        shift = 4'd8 - nb;
        return 8'hFF >> shift;
    endfunction

endpackage

// File: rtl/pcap_word_buf.sv
// Three-entry FIFO-order register buffer; entry 0 is always the head word.
// Latency: a pushed word is visible at head_dat the cycle after push_vld (when buffer was empty).
// Backpressure: none internally; caller must not push when full (such pushes are dropped).
// Ports: core_clk/arst_n clock and async active-low reset; push_vld/push_dat write side;
//        pop_vld removes the head; head_dat is entry 0; count is occupancy 0..3.
module pcap_word_buf #(
    parameter int W = 144
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic [W-1:0] head_dat,
    output logic [1:0]   count
);

    logic [W-1:0] mem [3];
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;
    logic [1:0]   wslot;

    assign do_push = push_vld && (cnt != 2'd3);
    assign do_pop  = pop_vld && (cnt != 2'd0);
    // A simultaneous pop shifts everything down one slot, so the write lands one lower.
    assign wslot   = cnt - {1'b0, do_pop};

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
            cnt <= 2'd0;
        end else begin
            if (do_pop) begin
                mem[0] <= mem[1];
                mem[1] <= mem[2];
            end
            // Later assignment wins over the shift above for the written slot.
            if (do_push) begin
                case (wslot)
                    2'd0:    mem[0] <= push_dat;
                    2'd1:    mem[1] <= push_dat;
                    default: mem[2] <= push_dat;
                endcase
            end
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_dat = mem[0];
    assign count    = cnt;

endmodule

// File: rtl/pcap_replay_fifo_unpacker.sv
// Serialises 144-bit replay FIFO words into one or two 64-bit AXI4-Stream beats; counts packets, flags sop/eop errors.
// Latency: fifo_rd_en in cycle N -> word buffered end of N+1 -> m_axis_tvalid in N+2; one beat per cycle sustained.
// Backpressure: m_axis_tready stalls the head beat; reads stop once buffered + in-flight words reach 3 (no tready->rd_en path).
// Ports: axi_aclk/axi_resetn clock and async active-low reset; fifo_dout/fifo_empty/fifo_rd_en standard-mode FIFO read port;
//        m_axis_* 64-bit AXIS master; pkt_count packets emitted (wraps); proto_err sticky framing error.
module pcap_replay_fifo_unpacker
    import pcap_replay_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH = 64,
    parameter int C_FIFO_WIDTH        = 144
) (
    input  logic                             axi_aclk,
    input  logic                             axi_resetn,
    input  logic [C_FIFO_WIDTH-1:0]          fifo_dout,
    input  logic                             fifo_empty,
    output logic                             fifo_rd_en,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [31:0]                      pkt_count,
    output logic                             proto_err
);

    logic              rd_arm;
    logic              inflight;
    logic              lane;
    logic              in_pkt;
    logic [1:0]        buf_cnt;
    logic [FIFO_W-1:0] head_raw;
    fifo_word_t        head;

    logic              beat_vld;
    logic              two_beat;
    logic              final_beat;
    logic [3:0]        tail_n;
    logic [STRB_W-1:0] beat_strb;
    logic [AXIS_W-1:0] beat_dat;
    logic              beat_last;
    logic              hs;
    logic              pop_vld;

    // rd_arm holds reads off during reset and for one cycle after, keeping
    // fifo_rd_en low in reset regardless of fifo_empty.
    assign fifo_rd_en = rd_arm && !fifo_empty &&
                        (({1'b0, buf_cnt} + {2'b00, inflight}) <= 3'd2);

    pcap_word_buf #(.W(FIFO_W)) u_word_buf (
        .core_clk (axi_aclk),
        .arst_n   (axi_resetn),
        .push_vld (inflight),
        .push_dat (fifo_dout),
        .pop_vld  (pop_vld),
        .head_dat (head_raw),
        .count    (buf_cnt)
    );

    assign head = fifo_word_t'(head_raw);

    // Non-eop words always carry 16 bytes; eop words need the high half only above 8 bytes.
    assign beat_vld   = (buf_cnt != 2'd0);
    assign two_beat   = !head.eop || head.nbytes_m1[3];
    assign final_beat = lane || !two_beat;
    // Bytes in the final beat of an eop word: n for a short word, n-8 for a long one.
    assign tail_n     = two_beat ? (head.nbytes_m1 - 4'd7) : (head.nbytes_m1 + 4'd1);
    assign beat_strb  = (head.eop && final_beat) ? strb_mask(tail_n) : {STRB_W{1'b1}};
    assign beat_dat   = lane ? head.data[DATA_W-1:AXIS_W] : head.data[AXIS_W-1:0];
    assign beat_last  = head.eop && final_beat;

    assign m_axis_tvalid = beat_vld;
    assign m_axis_tdata  = beat_vld ? beat_dat  : '0;
    assign m_axis_tstrb  = beat_vld ? beat_strb : '0;
    assign m_axis_tlast  = beat_vld && beat_last;

    assign hs      = beat_vld && m_axis_tready;
    assign pop_vld = hs && final_beat;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            rd_arm    <= 1'b0;
            inflight  <= 1'b0;
            lane      <= 1'b0;
            in_pkt    <= 1'b0;
            pkt_count <= 32'd0;
            proto_err <= 1'b0;
        end else begin
            rd_arm   <= 1'b1;
            inflight <= fifo_rd_en;
            if (hs) begin
                lane <= !final_beat;
                // Framing is judged once per word, on its first beat.
                if (!lane && (head.sop == in_pkt)) begin
                    proto_err <= 1'b1;
                end
                if (beat_last) begin
                    in_pkt    <= 1'b0;
                    pkt_count <= pkt_count + 32'd1;
                end else if (!lane) begin
                    in_pkt <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcap_replay_fifo_unpacker.sv
module tb_pcap_replay_fifo_unpacker;

    logic         clk = 1'b0;
    logic         axi_resetn;
    logic [143:0] fifo_dout;
    logic         fifo_empty = 1'b1;
    logic         fifo_rd_en;
    logic [63:0]  m_axis_tdata;
    logic [7:0]   m_axis_tstrb;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [31:0]  pkt_count;
    logic         proto_err;

    int errors = 0;
    int checks = 0;

    // Upstream FIFO contents and expected output beats.
    logic [143:0] fq [$];
    logic [63:0]  eb_dat [$];
    logic [7:0]   eb_strb [$];
    logic         eb_last [$];
    int           exp_pkts = 0;
    logic         err_m = 1'b0;
    logic         in_m = 1'b0;

    int           hs_cnt = 0;
    logic [7:0]   last_strb = 8'h00;
    logic         prev_stall = 1'b0;
    logic [63:0]  prev_dat;
    logic [7:0]   prev_strb;
    logic         prev_last;
    logic         tog = 1'b0;
    logic [143:0] w20 [20];

    pcap_replay_fifo_unpacker #(
        .C_M_AXIS_DATA_WIDTH (64),
        .C_FIFO_WIDTH        (144)
    ) dut (
        .axi_aclk      (clk),
        .axi_resetn    (axi_resetn),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_count     (pkt_count),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Standard-mode FIFO: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() != 0) fifo_dout <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
    end

    // Scoreboard and AXIS stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!axi_resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
                chk("stall_data", m_axis_tdata, prev_dat);
                chk("stall_strb", 64'(m_axis_tstrb), 64'(prev_strb));
                chk("stall_last", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                hs_cnt++;
                last_strb = m_axis_tstrb;
                if (eb_dat.size() == 0) begin
                    chk("spurious_beat", 64'(m_axis_tvalid), 64'd0);
                end else begin
                    chk("beat_data", m_axis_tdata, eb_dat.pop_front());
                    chk("beat_strb", 64'(m_axis_tstrb), 64'(eb_strb.pop_front()));
                    chk("beat_last", 64'(m_axis_tlast), 64'(eb_last.pop_front()));
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_dat   = m_axis_tdata;
            prev_strb  = m_axis_tstrb;
            prev_last  = m_axis_tlast;
        end
    end

    function automatic logic [143:0] mk(input logic sop, input logic eop, input logic [3:0] nbm1);
        logic [143:0] w;
        w[127:0]   = {$urandom, $urandom, $urandom, $urandom};
        w[128]     = sop;
        w[129]     = eop;
        w[133:130] = nbm1;
        w[143:134] = 10'($urandom);
        return w;
    endfunction

    // Reference: a word is cut into 8-byte beats of its valid bytes (16 when not eop).
    task automatic push_word(input logic [143:0] w);
        int n, nb, rem;
        fq.push_back(w);
        n  = (w[129]) ? int'(w[133:130]) + 1 : 16;
        nb = (n + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            rem = n - 8 * b;
            eb_dat.push_back(w[64*b +: 64]);
            eb_strb.push_back(rem >= 8 ? 8'hFF : 8'((1 << rem) - 1));
            eb_last.push_back(w[129] && (b == nb - 1));
        end
        if (w[128] == in_m) err_m = 1'b1;
        in_m = !w[129];
        if (w[129]) exp_pkts++;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (tog) m_axis_tready = ~m_axis_tready;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!m_axis_tvalid && k < 100) begin
            cycle();
            k++;
        end
        chk(tag, 64'(m_axis_tvalid), 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((eb_dat.size() != 0 || fq.size() != 0) && k < 1000) begin
            cycle();
            k++;
        end
        chk(tag, 64'(eb_dat.size()), 64'd0);
        cycle();
    endtask

    initial begin
        int k;
        int h0;
        axi_resetn    = 1'b0;
        m_axis_tready = 1'b0;
        fifo_dout     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_tstrb", 64'(m_axis_tstrb), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        axi_resetn = 1'b1;
        repeat (2) cycle();

        // Single short word: latency and one-beat output.
        m_axis_tready = 1'b1;
        push_word(mk(1'b1, 1'b1, 4'd4));
        k = 0;
        while (!fifo_rd_en && k < 20) begin
            cycle();
            k++;
        end
        chk("lat_rd_en", 64'(fifo_rd_en), 64'd1);
        cycle();
        chk("lat_n1_tvalid", 64'(m_axis_tvalid), 64'd0);
        cycle();
        chk("lat_n2_tvalid", 64'(m_axis_tvalid), 64'd1);
        wait_drain("single_drain");
        chk("single_strb", 64'(last_strb), 64'h1F);
        chk("single_pkt_count", 64'(pkt_count), 64'(exp_pkts));
        chk("single_proto_err", 64'(proto_err), 64'(err_m));

        // Two-word packet, 11 bytes in the tail word.
        push_word(mk(1'b1, 1'b0, 4'($urandom)));
        push_word(mk(1'b0, 1'b1, 4'd10));
        wait_drain("pkt2_drain");
        chk("pkt2_tail_strb", 64'(last_strb), 64'h07);
        chk("pkt2_pkt_count", 64'(pkt_count), 64'(exp_pkts));

        // 20 back-to-back short words at full rate.
        for (int i = 0; i < 20; i++) begin
            w20[i] = mk(1'b1, 1'b1, 4'($urandom_range(0, 7)));
            push_word(w20[i]);
        end
        wait_valid("b2b_first_valid");
        h0 = hs_cnt;
        repeat (20) cycle();
        chk("b2b_beats_in_20_cycles", 64'(hs_cnt - h0), 64'd20);
        wait_drain("b2b_drain");
        chk("b2b_pkt_count", 64'(pkt_count), 64'(exp_pkts));

        // Same stream with tready toggling every cycle.
        for (int i = 0; i < 20; i++) push_word(w20[i]);
        tog = 1'b1;
        wait_drain("tog_drain");
        tog = 1'b0;
        m_axis_tready = 1'b1;
        chk("tog_pkt_count", 64'(pkt_count), 64'(exp_pkts));
        chk("tog_proto_err", 64'(proto_err), 64'(err_m));

        // Framing errors: missing sop, then a sop inside a packet.
        push_word(mk(1'b0, 1'b1, 4'($urandom_range(0, 15))));
        wait_drain("nosop_drain");
        chk("nosop_proto_err", 64'(proto_err), 64'(err_m));
        push_word(mk(1'b1, 1'b0, 4'($urandom)));
        push_word(mk(1'b1, 1'b1, 4'($urandom_range(0, 15))));
        wait_drain("midsop_drain");
        chk("midsop_proto_err", 64'(proto_err), 64'(err_m));
        chk("midsop_pkt_count", 64'(pkt_count), 64'(exp_pkts));

        // Reset while a two-beat word is half sent.
        m_axis_tready = 1'b0;
        push_word(mk(1'b1, 1'b0, 4'($urandom)));
        push_word(mk(1'b0, 1'b1, 4'd15));
        wait_valid("mid_valid");
        repeat (3) cycle();
        m_axis_tready = 1'b1;
        cycle();
        m_axis_tready = 1'b0;
        chk("mid_beat0_taken", 64'(eb_dat.size()), 64'd3);
        axi_resetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_rst_tdata", m_axis_tdata, 64'd0);
        chk("mid_rst_tstrb", 64'(m_axis_tstrb), 64'd0);
        chk("mid_rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("mid_rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("mid_rst_proto_err", 64'(proto_err), 64'd0);
        fq.delete();
        eb_dat.delete();
        eb_strb.delete();
        eb_last.delete();
        exp_pkts = 0;
        err_m    = 1'b0;
        in_m     = 1'b0;
        repeat (2) cycle();
        axi_resetn = 1'b1;
        repeat (2) cycle();
        chk("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        m_axis_tready = 1'b1;
        push_word(mk(1'b1, 1'b1, 4'd12));
        wait_drain("post_rst_drain");
        chk("post_rst_pkt_count", 64'(pkt_count), 64'(exp_pkts));
        chk("post_rst_proto_err", 64'(proto_err), 64'(err_m));
        chk("post_rst_tail_strb", 64'(last_strb), 64'h1F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
